data_sync_launcher: RTL and testbench

Source-domain transmitter for the multi-bit enable-qualified synchronizer. It accepts a word from local logic over a valid/ready handshake and drives it onto a registered `unsync_bus`. It then raises `bus_enable` for a fixed number of source cycles and drops it for a fixed gap, so the destination-side synchronizer sees exactly one clean rising edge per word while the bus is stable. It sits in the sending clock domain, directly feeding the crossing wires.

---
 rtl/data_sync_launcher.sv | 84 ++++++++
 tb/tb_data_sync_launcher.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_launcher.sv
// Source-domain launcher for an enable-qualified multi-bit synchronizer: registers a word onto
// unsync_bus, then holds bus_enable high for HOLD_CYCLES and low for GAP_CYCLES per word.
module data_sync_launcher #(
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 tx_done
);

    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
        $fatal(1, "data_sync_launcher: HOLD_CYCLES and GAP_CYCLES must both be >= 1");
    end

    localparam int CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [BUS_WIDTH-1:0]   bus_q;
    logic                   en_q;
    logic                   done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bus_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        bus_q   <= in_data;
                        en_q    <= 1'b1;
                        cnt_q   <= HoldLoad;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        cnt_q   <= GapLoad;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StGap: begin
                    // bus_q stays put here so data is stable across the enable's falling edge.
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign unsync_bus = bus_q;
    assign bus_enable = en_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_data_sync_launcher.sv
// Directed bench for data_sync_launcher: default, minimum and end-to-end configurations,
// the last one feeding a two-stage enable synchronizer on a 1.7x slower clock.
module tb_data_sync_launcher;

    logic clk  = 1'b0;
    logic dclk = 1'b0;
    logic rst  = 1'b1;

    always #10 clk  = ~clk;
    always #17 dclk = ~dclk;

    int checks = 0;
    int errors = 0;

    // Default 8/4/4 instance
    logic [7:0] in_data   = '0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic       tx_done;

    // Minimum 1/1 instance
    logic [7:0] in_data_m  = '0;
    logic       in_valid_m = 1'b0;
    logic       in_ready_m;
    logic [7:0] unsync_bus_m;
    logic       bus_enable_m;
    logic       tx_done_m;

    // End-to-end 6/6 instance
    logic [7:0] in_data_e  = '0;
    logic       in_valid_e = 1'b0;
    logic       in_ready_e;
    logic [7:0] unsync_bus_e;
    logic       bus_enable_e;
    logic       tx_done_e;

    data_sync_launcher #(.BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4)) dut (
        .CLK        (clk),
        .RST        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .tx_done    (tx_done)
    );

    data_sync_launcher #(.BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_min (
        .CLK        (clk),
        .RST        (rst),
        .in_data    (in_data_m),
        .in_valid   (in_valid_m),
        .in_ready   (in_ready_m),
        .unsync_bus (unsync_bus_m),
        .bus_enable (bus_enable_m),
        .tx_done    (tx_done_m)
    );

    data_sync_launcher #(.BUS_WIDTH(8), .HOLD_CYCLES(6), .GAP_CYCLES(6)) dut_e2e (
        .CLK        (clk),
        .RST        (rst),
        .in_data    (in_data_e),
        .in_valid   (in_valid_e),
        .in_ready   (in_ready_e),
        .unsync_bus (unsync_bus_e),
        .bus_enable (bus_enable_e),
        .tx_done    (tx_done_e)
    );

    // Receiving synchronizer (NUM_STAGES=2) with rising-edge capture of the stable bus.
    logic [2:0] rx_sync = '0;
    logic [7:0] rx_q[$];

    always @(posedge dclk) begin
        rx_sync <= {rx_sync[1:0], bus_enable_e};
        if (rx_sync[1] && !rx_sync[2]) rx_q.push_back(unsync_bus_e);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] w;

    initial begin
        // Reset with a pending word that must not be captured.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_bus", unsync_bus, 8'h00);
            check_eq("rst_en", bus_enable, 1'b0);
            check_eq("rst_done", tx_done, 1'b0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_bus_after", unsync_bus, 8'h00);

        // Single word 0xA5 accepted at edge k.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check_eq($sformatf("single_en_c%0d", c), bus_enable, (c <= 4) ? 1'b1 : 1'b0);
            check_eq($sformatf("single_bus_c%0d", c), unsync_bus, 8'hA5);
            check_eq($sformatf("single_done_c%0d", c), tx_done, (c == 9) ? 1'b1 : 1'b0);
            check_eq($sformatf("single_rdy_c%0d", c), in_ready, (c <= 8) ? 1'b0 : 1'b1);
            tick();
        end

        // Back-to-back with in_valid held; data changes mid-word and must wait.
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) in_data = 8'h22;
            check_eq($sformatf("b2b_bus_c%0d", c), unsync_bus, (c <= 9) ? 8'h11 : 8'h22);
            check_eq($sformatf("b2b_en_c%0d", c), bus_enable,
                     (c <= 4 || c == 10) ? 1'b1 : 1'b0);
            if (c == 9) begin
                check_eq("b2b_done_c9", tx_done, 1'b1);
                check_eq("b2b_rdy_c9", in_ready, 1'b1);
            end
            if (c == 10) in_valid = 1'b0;
            else tick();
        end
        for (int i = 0; i < 8; i++) tick();
        check_eq("b2b_second_done", tx_done, 1'b1);
        check_eq("b2b_second_rdy", in_ready, 1'b1);
        tick();

        // Reset in the middle of HOLD.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        check_eq("midrst_en_k1", bus_enable, 1'b1);
        check_eq("midrst_bus_k1", unsync_bus, 8'h3C);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_en", bus_enable, 1'b0);
        check_eq("midrst_bus", unsync_bus, 8'h00);
        check_eq("midrst_rdy", in_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("midrst_nodone_%0d", i), tx_done, 1'b0);
            tick();
        end

        // Minimum config: words 1,2,3 with in_valid held continuously.
        in_valid_m = 1'b1;
        in_data_m  = 8'h01;
        tick();
        for (int c = 1; c <= 9; c++) begin
            int wi;
            int ph;
            wi = (c - 1) / 3 + 1;
            ph = (c - 1) % 3;
            check_eq($sformatf("min_en_c%0d", c), bus_enable_m, (ph == 0) ? 1'b1 : 1'b0);
            check_eq($sformatf("min_bus_c%0d", c), unsync_bus_m, wi[7:0]);
            check_eq($sformatf("min_rdy_c%0d", c), in_ready_m, (ph == 2) ? 1'b1 : 1'b0);
            check_eq($sformatf("min_done_c%0d", c), tx_done_m, (ph == 2) ? 1'b1 : 1'b0);
            if (ph == 0) begin
                if (wi < 3) in_data_m = 8'(wi + 1);
                else in_valid_m = 1'b0;
            end
            tick();
        end

        // End-to-end through the slow-clock receiver.
        rx_q.delete();
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 50 && !in_ready_e; i++) tick();
            check_eq($sformatf("e2e_ready_%0d", n), in_ready_e, 1'b1);
            w = 8'($urandom_range(0, 255));
            exp_q.push_back(w);
            in_valid_e = 1'b1;
            in_data_e  = w;
            tick();
            in_valid_e = 1'b0;
            in_data_e  = ~w;
        end
        for (int i = 0; i < 40; i++) tick();
        check_eq("e2e_count", rx_q.size(), 16);
        for (int n = 0; n < 16 && n < rx_q.size(); n++) begin
            check_eq($sformatf("e2e_word_%0d", n), rx_q[n], exp_q[n]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
